// File: rtl/retire_store_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : retire_store_buffer_pkg                                      |
// | Description : Shared types, bus encodings and size-mask helper for the      |
// |               post-retire store buffer.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package retire_store_buffer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_e       size;
    logic            valid;
  } sb_entry_t;

  // Keeps the low bytes that an access of the given size actually carries.
  function automatic logic [XLEN-1:0] size_mask(input mem_size_e size);
    case (size)
      BYTE:    return XLEN'(8'hFF);
      HALF:    return XLEN'(16'hFFFF);
      default: return {XLEN{1'b1}};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/retire_store_buffer_sb_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : retire_store_buffer_sb_match                                 |
// | Description : Youngest-first word-match / cover search over the buffer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module retire_store_buffer_sb_match
  import retire_store_buffer_pkg::*;
#(
  parameter  int SB_DEPTH = 4,
  localparam int SB_IDX_W = $clog2(SB_DEPTH)
) (
  input  logic [SB_DEPTH-1:0] i_valid,
  input  logic [XLEN-1:0]     i_addr [SB_DEPTH],
  input  mem_size_e           i_size [SB_DEPTH],
  input  logic [SB_IDX_W-1:0] i_tail,
  input  logic [XLEN-1:0]     i_ld_addr,
  input  mem_size_e           i_ld_size,
  output logic                o_match,
  output logic                o_cover,
  output logic [SB_IDX_W-1:0] o_match_idx
);

  logic [SB_IDX_W-1:0] w_idx;

  // Live entries are exactly the valid ones, so walking back from tail-1
  // over valid slots visits them youngest first.
  always_comb begin
    o_match     = 1'b0;
    o_cover     = 1'b0;
    o_match_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = i_tail - SB_IDX_W'(k + 1);
      if (!o_match && i_valid[w_idx] &&
          (i_addr[w_idx][XLEN-1:2] == i_ld_addr[XLEN-1:2])) begin
        o_match     = 1'b1;
        o_match_idx = w_idx;
        o_cover     = (i_addr[w_idx] == i_ld_addr) && (i_size[w_idx] >= i_ld_size);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/retire_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : retire_store_buffer                                          |
// | Description : Post-retire FIFO store buffer draining to Dmem, loads have   |
// |               bus priority. Optional forwarding under `STORE_FWD_EN`.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module retire_store_buffer
  import retire_store_buffer_pkg::*;
#(
  parameter  int SB_DEPTH = 4,
  localparam int SB_IDX_W = $clog2(SB_DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  bus_cmd_e        st_command,
  input  mem_size_e       st_size,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            sb_full,
  output logic            sb_empty,
  output logic            sb_overflow,
  input  logic            ld_req,
  input  logic [XLEN-1:0] ld_addr,
  input  mem_size_e       ld_size,
  output logic            ld_conflict,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output bus_cmd_e        proc2Dmem_command,
  output mem_size_e       proc2Dmem_size,
  output logic [XLEN-1:0] proc2Dmem_addr,
  output logic [XLEN-1:0] proc2Dmem_data,
  input  logic            dmem_grant
);

  sb_entry_t             r_entries [SB_DEPTH];
  logic [SB_IDX_W-1:0]   r_head;
  logic [SB_IDX_W-1:0]   r_tail;
  logic [SB_IDX_W:0]     r_count;
  logic                  r_sb_full;
  logic                  r_sb_empty;
  logic                  r_sb_overflow;

  logic [SB_DEPTH-1:0]   w_valid;
  logic [XLEN-1:0]       w_addr [SB_DEPTH];
  mem_size_e             w_size [SB_DEPTH];
  logic                  w_match;
  logic                  w_cover;
  logic [SB_IDX_W-1:0]   w_match_idx;
  logic                  w_fwd_hit;
  logic                  w_ld_conflict;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic [SB_IDX_W:0]     w_count_next;

  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_view
    assign w_valid[gi] = r_entries[gi].valid;
    assign w_addr[gi]  = r_entries[gi].addr;
    assign w_size[gi]  = r_entries[gi].size;
  end

  retire_store_buffer_sb_match #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb_match (
    .i_valid     (w_valid),
    .i_addr      (w_addr),
    .i_size      (w_size),
    .i_tail      (r_tail),
    .i_ld_addr   (ld_addr),
    .i_ld_size   (ld_size),
    .o_match     (w_match),
    .o_cover     (w_cover),
    .o_match_idx (w_match_idx)
  );

`ifdef STORE_FWD_EN
  assign w_fwd_hit     = ld_req && w_match && w_cover;
  assign w_ld_conflict = ld_req && w_match && !w_cover;
  assign fwd_data      = w_fwd_hit ? (r_entries[w_match_idx].data & size_mask(ld_size)) : '0;
`else
  logic w_unused_fwd;
  assign w_unused_fwd  = ^{w_cover, w_match_idx};
  assign w_fwd_hit     = 1'b0;
  assign w_ld_conflict = ld_req && w_match;
  assign fwd_data      = '0;
`endif

  assign fwd_hit     = w_fwd_hit;
  assign ld_conflict = w_ld_conflict;

  // Arbitration looks only at registered buffer state plus the live load.
  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_size    = BYTE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    if (!reset) begin
      proc2Dmem_command = BUS_NONE;
    end else if (ld_req && !w_ld_conflict && !w_fwd_hit) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_size    = ld_size;
      proc2Dmem_addr    = ld_addr;
    end else if (!r_sb_empty) begin
      proc2Dmem_command = BUS_STORE;
      proc2Dmem_size    = r_entries[r_head].size;
      proc2Dmem_addr    = r_entries[r_head].addr;
      proc2Dmem_data    = r_entries[r_head].data;
    end
  end

  assign w_push_req   = (st_command == BUS_STORE);
  assign w_push       = w_push_req && !r_sb_full;
  assign w_pop        = (proc2Dmem_command == BUS_STORE) && dmem_grant;
  assign w_count_next = r_count + (SB_IDX_W+1)'(w_push) - (SB_IDX_W+1)'(w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_sb_full     <= 1'b0;
      r_sb_empty    <= 1'b1;
      r_sb_overflow <= 1'b0;
    end else begin
      // Push lands at tail and pop retires head; they can only alias when
      // the buffer is empty or full, where one of the two is blocked.
      if (w_push) begin
        r_entries[r_tail] <= '{addr: st_addr, data: st_data, size: st_size, valid: 1'b1};
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      if (w_push_req && r_sb_full) begin
        r_sb_overflow <= 1'b1;
      end
      r_count    <= w_count_next;
      r_sb_full  <= (w_count_next == (SB_IDX_W+1)'(SB_DEPTH));
      r_sb_empty <= (w_count_next == '0);
    end
  end

  assign sb_full     = r_sb_full;
  assign sb_empty    = r_sb_empty;
  assign sb_overflow = r_sb_overflow;

endmodule
`default_nettype wire

// File: tb/tb_retire_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_retire_store_buffer                                       |
// | Description : Directed + random bench with a queue-based reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_retire_store_buffer;
  import retire_store_buffer_pkg::*;

  localparam int c_DEPTH = 4;

  logic        clock;
  logic        reset;
  bus_cmd_e    st_command;
  mem_size_e   st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_overflow;
  logic        ld_req;
  logic [31:0] ld_addr;
  mem_size_e   ld_size;
  logic        ld_conflict;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  bus_cmd_e    proc2Dmem_command;
  mem_size_e   proc2Dmem_size;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic        dmem_grant;

  retire_store_buffer #(.SB_DEPTH(c_DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .st_command        (st_command),
    .st_size           (st_size),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .sb_full           (sb_full),
    .sb_empty          (sb_empty),
    .sb_overflow       (sb_overflow),
    .ld_req            (ld_req),
    .ld_addr           (ld_addr),
    .ld_size           (ld_size),
    .ld_conflict       (ld_conflict),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2Dmem_size    (proc2Dmem_size),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2Dmem_data    (proc2Dmem_data),
    .dmem_grant        (dmem_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t q[$];
  bit  m_ovf;
  int  n_asserts = 0;
  int  n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_mask(input logic [1:0] sz);
    logic [63:0] one;
    one = 64'd1;
    return (sz >= 2'd2) ? 32'hFFFF_FFFF : 32'((one << (8 << sz)) - one);
  endfunction

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input bit push, input logic [1:0] ssz, input logic [31:0] sa,
                      input logic [31:0] sd, input bit lr, input logic [31:0] la,
                      input logic [1:0] lsz, input bit g);
    int m;
    bit e_hit, e_conf, was_full;
    logic [1:0]  e_cmd, e_size;
    logic [31:0] e_addr, e_data, e_fdata;
    @(negedge clock);
    st_command = push ? BUS_STORE : BUS_NONE;
    st_size    = mem_size_e'(ssz);
    st_addr    = sa;
    st_data    = sd;
    ld_req     = lr;
    ld_addr    = la;
    ld_size    = mem_size_e'(lsz);
    dmem_grant = g;
    #1;
    m = -1;
    for (int i = q.size() - 1; i >= 0; i--)
      if (m < 0 && q[i].addr[31:2] == la[31:2]) m = i;
    e_hit = 0; e_conf = 0; e_fdata = 32'h0;
    if (lr && m >= 0) begin
`ifdef STORE_FWD_EN
      if (q[m].addr == la && q[m].size >= lsz) begin
        e_hit   = 1;
        e_fdata = q[m].data & exp_mask(lsz);
      end else e_conf = 1;
`else
      e_conf = 1;
`endif
    end
    e_cmd = 2'd0; e_size = 2'd0; e_addr = 32'h0; e_data = 32'h0;
    if (lr && !e_conf && !e_hit) begin
      e_cmd = 2'd1; e_size = lsz; e_addr = la;
    end else if (q.size() > 0) begin
      e_cmd = 2'd2; e_size = q[0].size; e_addr = q[0].addr; e_data = q[0].data;
    end
    chk("sb_full",     32'(sb_full),      32'(q.size() == c_DEPTH));
    chk("sb_empty",    32'(sb_empty),     32'(q.size() == 0));
    chk("sb_overflow", 32'(sb_overflow),  32'(m_ovf));
    chk("ld_conflict", 32'(ld_conflict),  32'(e_conf));
    chk("fwd_hit",     32'(fwd_hit),      32'(e_hit));
    chk("fwd_data",    fwd_data,          e_fdata);
    chk("bus_cmd",     32'(proc2Dmem_command), 32'(e_cmd));
    chk("bus_size",    32'(proc2Dmem_size),    32'(e_size));
    chk("bus_addr",    proc2Dmem_addr,    e_addr);
    chk("bus_data",    proc2Dmem_data,    e_data);
    was_full = (q.size() == c_DEPTH);
    if (e_cmd == 2'd2 && g) void'(q.pop_front());
    if (push) begin
      if (was_full) m_ovf = 1;
      else q.push_back('{addr: sa, data: sd, size: ssz});
    end
  endtask

  task automatic idle(input bit g);
    step(0, 2'd0, 32'h0, 32'h0, 0, 32'h0, 2'd0, g);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input bit g);
    step(1, sz, a, d, 0, 32'h0, 2'd0, g);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    st_command = BUS_NONE;
    ld_req     = 1'b0;
    dmem_grant = 1'b0;
    q.delete();
    m_ovf = 0;
    #1;
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_cmd",   32'(proc2Dmem_command), 32'(BUS_NONE));
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; st_command = BUS_NONE; st_size = BYTE; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; ld_size = BYTE; dmem_grant = 1'b0;
    q.delete(); m_ovf = 0;

    // Reset state, then reset in the middle of a drain.
    idle(0);
    chk("rst_full", 32'(sb_full), 32'd0);
    @(negedge clock); reset = 1'b1;
    st(WORD, 32'h10, 32'h1111_0000, 0);
    st(WORD, 32'h14, 32'h2222_0000, 0);
    st(WORD, 32'h18, 32'h3333_0000, 0);
    idle(1);
    @(negedge clock);
    st_command = BUS_NONE; dmem_grant = 1'b1;
    #2 reset = 1'b0;
    q.delete(); m_ovf = 0;
    #1 chk("mid_rst_empty", 32'(sb_empty), 32'd1);
    @(posedge clock); #1;
    chk("mid_rst_edge_empty", 32'(sb_empty), 32'd1);
    chk("mid_rst_edge_cmd", 32'(proc2Dmem_command), 32'(BUS_NONE));
    @(negedge clock); reset = 1'b1;

    // Fill and overflow.
    for (int i = 0; i < 4; i++) st(WORD, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i), 0);
    st(WORD, 32'h30, 32'hBAD, 0);
    chk("fill_full", 32'(sb_full), 32'd1);
    idle(0);
    chk("fill_ovf",  32'(sb_overflow), 32'd1);
    chk("fill_head", proc2Dmem_addr, 32'h20);
    do_reset();

    // Continuous push/pop through the pointer wrap.
    st(WORD, 32'h200, 32'h0, 1);
    for (int i = 1; i <= 10; i++) begin
      st(WORD, 32'h200 + 32'(4 * i), 32'(i), 1);
      chk("wrap_addr", proc2Dmem_addr, 32'h200 + 32'(4 * (i - 1)));
      chk("wrap_nonempty", 32'(sb_empty), 32'd0);
    end
    idle(1);
    idle(1);
    do_reset();

    // Load priority over pending stores.
    st(WORD, 32'h10, 32'h1, 0);
    st(WORD, 32'h14, 32'h2, 0);
    step(0, 2'd0, 32'h0, 32'h0, 1, 32'h100, WORD, 0);
    chk("prio_load", 32'(proc2Dmem_command), 32'(BUS_LOAD));
    chk("prio_addr", proc2Dmem_addr, 32'h100);
    idle(0);
    chk("prio_store", 32'(proc2Dmem_command), 32'(BUS_STORE));
    do_reset();

    // Byte load under a covering word store.
    st(WORD, 32'h40, 32'hDEAD_BEEF, 0);
    step(0, 2'd0, 32'h0, 32'h0, 1, 32'h40, BYTE, 0);
`ifdef STORE_FWD_EN
    chk("fwd_hit_dir",  32'(fwd_hit), 32'd1);
    chk("fwd_data_dir", fwd_data, 32'hEF);
`else
    chk("nofwd_conflict", 32'(ld_conflict), 32'd1);
`endif
    chk("fwd_no_load", 32'(proc2Dmem_command), 32'(BUS_STORE));
    do_reset();

    // Partial overlap: conflict, drain, then the load goes out.
    st(BYTE, 32'h41, 32'h5A, 0);
    step(0, 2'd0, 32'h0, 32'h0, 1, 32'h40, WORD, 1);
    chk("part_conflict", 32'(ld_conflict), 32'd1);
    chk("part_drain", proc2Dmem_addr, 32'h41);
    step(0, 2'd0, 32'h0, 32'h0, 1, 32'h40, WORD, 1);
    chk("part_load", 32'(proc2Dmem_command), 32'(BUS_LOAD));
    do_reset();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned ra, rl;
      ra = $urandom_range(0, 8);
      rl = $urandom_range(0, 8);
      step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           (ra == 8) ? 32'h100 : 32'h40 + ra, $urandom,
           $urandom_range(0, 1) == 1,
           (rl == 8) ? 32'h100 : 32'h40 + rl, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
